// File: rtl/memory_pkg.sv
// Shared constants, clear-sequencer state type and byte-lane merge helper
// for the parametrised dual-port RAM.
package memory_pkg;

  localparam int unsigned WRITE_FIRST    = 0;
  localparam int unsigned READ_FIRST     = 1;
  localparam int unsigned MAX_DATA_WIDTH = 512;
  localparam int unsigned MAX_LANES      = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_t;

  // Words are zero-extended to MAX_DATA_WIDTH so one function serves every DATA_WIDTH.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      mask
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Output register stages and valid flag for one RAM port; READ_LATENCY of 1 or 2
// falling edges from access capture to read_data.
module ram_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  logic [DATA_WIDTH-1:0] stage_data;
  logic                  stage_valid;

  // Data holds its last value whenever no access is accepted.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stage_data  <= '0;
      stage_valid <= 1'b0;
    end else begin
      stage_valid <= load;
      if (load) begin
        stage_data <= data_in;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign data_out  = stage_data;
    assign valid_out = stage_valid;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= stage_valid;
        if (stage_valid) begin
          out_data <= stage_data;
        end
      end
    end

    assign data_out  = out_data;
    assign valid_out = out_valid;
  end

endmodule

// File: rtl/dual_port_ram_p.sv
// Parametrised true-dual-port RAM with byte lanes, selectable write mode and read
// latency, post-reset clear sequencer and write-write collision arbitration.
module dual_port_ram_p
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address_a,
  input  logic [ADDR_WIDTH-1:0]   address_b,
  input  logic [DATA_WIDTH-1:0]   write_data_a,
  input  logic [DATA_WIDTH-1:0]   write_data_b,
  input  logic                    write_enable_a,
  input  logic                    write_enable_b,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_a,
  input  logic [DATA_WIDTH/8-1:0] byte_enable_b,
  output logic [DATA_WIDTH-1:0]   read_data_a,
  output logic [DATA_WIDTH-1:0]   read_data_b,
  output logic                    read_valid_a,
  output logic                    read_valid_b,
  output logic                    busy,
  output logic                    collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clear_state_t          state;
  clear_state_t          state_next;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic [ADDR_WIDTH-1:0] clear_count_next;
  logic                  clear_we;
  logic                  accept;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clear_count <= '0;
    end else begin
      state       <= state_next;
      clear_count <= clear_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    clear_count_next = clear_count;
    clear_we         = 1'b0;
    case (state)
      CLEAR: begin
        clear_we         = !reset;
        clear_count_next = clear_count + 1'b1;
        if (clear_count == '1) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = READY;
      end
    endcase
  end

  assign busy   = (state == CLEAR);
  assign accept = (state == READY) && !reset;

  logic [DATA_WIDTH-1:0] old_a;
  logic [DATA_WIDTH-1:0] old_b;
  logic [DATA_WIDTH-1:0] merged_a;
  logic [DATA_WIDTH-1:0] merged_b;
  logic [DATA_WIDTH-1:0] combined;
  logic [DATA_WIDTH-1:0] final_a;
  logic [DATA_WIDTH-1:0] final_b;
  logic [DATA_WIDTH-1:0] resp_a;
  logic [DATA_WIDTH-1:0] resp_b;
  logic                  same_addr;

  assign old_a = mem[address_a];
  assign old_b = mem[address_b];

  assign merged_a = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(old_a),
                                            MAX_DATA_WIDTH'(write_data_a),
                                            MAX_LANES'(byte_enable_a)));
  assign merged_b = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(old_b),
                                            MAX_DATA_WIDTH'(write_data_b),
                                            MAX_LANES'(byte_enable_b)));

  assign same_addr = write_enable_a && write_enable_b && (address_a == address_b);

  // B's merge is applied first so A overrides it on lanes both ports enable.
  assign combined = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(merged_b),
                                            MAX_DATA_WIDTH'(write_data_a),
                                            MAX_LANES'(byte_enable_a)));

  assign final_a = same_addr ? combined : merged_a;
  assign final_b = same_addr ? combined : merged_b;

  // A reading port always sees the stored word, even if the other port writes it.
  assign resp_a = (write_enable_a && (WRITE_MODE != READ_FIRST)) ? final_a : old_a;
  assign resp_b = (write_enable_b && (WRITE_MODE != READ_FIRST)) ? final_b : old_b;

  always_ff @(negedge clock) begin
    if (clear_we) begin
      mem[clear_count] <= '0;
    end else if (accept) begin
      if (same_addr) begin
        mem[address_a] <= combined;
      end else begin
        if (write_enable_a) begin
          mem[address_a] <= merged_a;
        end
        if (write_enable_b) begin
          mem[address_b] <= merged_b;
        end
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      collision <= 1'b0;
    end else begin
      collision <= accept && same_addr;
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .data_in  (resp_a),
    .data_out (read_data_a),
    .valid_out(read_valid_a)
  );

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .data_in  (resp_b),
    .data_out (read_data_b),
    .valid_out(read_valid_b)
  );

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: three configurations (write-first/L1, read-first/L1,
// write-first/L2) driven by one directed stream, checked against a word-level model.
module tb_dual_port_ram_p;

  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int NDUT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic [1:0]  be_a, be_b;

  logic [15:0] rd_a [NDUT];
  logic [15:0] rd_b [NDUT];
  logic        rv_a [NDUT];
  logic        rv_b [NDUT];
  logic        busy [NDUT];
  logic        coll [NDUT];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dual_port_ram_p #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .READ_LATENCY  ((g == 2) ? 2 : 1),
      .WRITE_MODE    ((g == 1) ? 1 : 0),
      .CLEAR_ON_RESET(1),
      .INIT_FILE     ("")
    ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .address_a     (addr_a),
      .address_b     (addr_b),
      .write_data_a  (wd_a),
      .write_data_b  (wd_b),
      .write_enable_a(we_a),
      .write_enable_b(we_b),
      .byte_enable_a (be_a),
      .byte_enable_b (be_b),
      .read_data_a   (rd_a[g]),
      .read_data_b   (rd_b[g]),
      .read_valid_a  (rv_a[g]),
      .read_valid_b  (rv_b[g]),
      .busy          (busy[g]),
      .collision     (coll[g])
    );
  end

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb [2*NDUT][$];
  logic [15:0] model [16];
  int          checks;
  int          errors;
  int          edge_n;
  int          clear_left;
  logic        exp_coll;

  function automatic int wm_of(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 2) ? 2 : 1;
  endfunction

  function automatic logic [15:0] lane_mix(input logic [15:0] o, input logic [15:0] n,
                                           input logic [1:0] m);
    return {(m[1] ? n[15:8] : o[15:8]), (m[0] ? n[7:0] : o[7:0])};
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive_a(input logic we, input logic [3:0] addr, input logic [15:0] data,
                         input logic [1:0] be);
    we_a = we; addr_a = addr; wd_a = data; be_a = be;
  endtask

  task automatic drive_b(input logic we, input logic [3:0] addr, input logic [15:0] data,
                         input logic [1:0] be);
    we_b = we; addr_b = addr; wd_b = data; be_b = be;
  endtask

  task automatic check_port(input int k, input logic valid, input logic [15:0] data);
    exp_t  e;
    string tag;
    tag = $sformatf("d%0d_port_%s", k / 2, (k % 2 == 0) ? "a" : "b");
    if (valid === 1'b1) begin
      checks++;
      assert (sb[k].size() != 0) else begin
        errors++;
        $error("FAIL %s_spurious_valid: observed valid 1 expected valid 0", tag);
      end
      if (sb[k].size() != 0) begin
        e = sb[k].pop_front();
        check({tag, "_data"}, data, e.data);
        check({tag, "_edge"}, 16'(edge_n), 16'(e.due));
      end
    end else if (sb[k].size() != 0 && sb[k][0].due <= edge_n) begin
      e = sb[k].pop_front();
      check({tag, "_valid"}, 16'(valid), 16'd1);
    end
  endtask

  task automatic cycle();
    logic [15:0] old_a, old_b, mrg_a, mrg_b, fin_a, fin_b;
    logic        same;
    exp_t        e;
    @(negedge clock);
    edge_n++;
    exp_coll = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      old_a = model[addr_a];
      old_b = model[addr_b];
      mrg_a = lane_mix(old_a, wd_a, be_a);
      mrg_b = lane_mix(old_b, wd_b, be_b);
      same  = we_a && we_b && (addr_a == addr_b);
      if (same) begin
        fin_a = lane_mix(mrg_b, wd_a, be_a);
        fin_b = fin_a;
        model[addr_a] = fin_a;
      end else begin
        fin_a = mrg_a;
        fin_b = mrg_b;
        if (we_a) model[addr_a] = mrg_a;
        if (we_b) model[addr_b] = mrg_b;
      end
      exp_coll = same;
      for (int g = 0; g < NDUT; g++) begin
        e.due  = edge_n + lat_of(g) - 1;
        e.data = (we_a && wm_of(g) == 0) ? fin_a : old_a;
        sb[2*g].push_back(e);
        e.data = (we_b && wm_of(g) == 0) ? fin_b : old_b;
        sb[2*g+1].push_back(e);
      end
    end
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("d%0d_busy", g), 16'(busy[g]), 16'(clear_left > 0));
      check($sformatf("d%0d_collision", g), 16'(coll[g]), 16'(exp_coll));
      check_port(2*g, rv_a[g], rd_a[g]);
      check_port(2*g+1, rv_b[g], rd_b[g]);
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("d%0d_rst_busy", g), 16'(busy[g]), 16'd1);
      check($sformatf("d%0d_rst_valid_a", g), 16'(rv_a[g]), 16'd0);
      check($sformatf("d%0d_rst_valid_b", g), 16'(rv_b[g]), 16'd0);
      check($sformatf("d%0d_rst_collision", g), 16'(coll[g]), 16'd0);
      check($sformatf("d%0d_rst_data_a", g), rd_a[g], 16'h0000);
      check($sformatf("d%0d_rst_data_b", g), rd_b[g], 16'h0000);
    end
    for (int k = 0; k < 2*NDUT; k++) sb[k].delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    clear_left = 16;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b0, 4'(i), 16'h0, 2'b00);
      drive_b(1'b0, 4'(15 - i), 16'h0, 2'b00);
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; edge_n = 0; clear_left = 0; exp_coll = 1'b0;
    drive_a(1'b0, 4'd0, 16'h0, 2'b00);
    drive_b(1'b0, 4'd0, 16'h0, 2'b00);
    do_reset();

    // Clear: a write to address 3 held for the whole clear must not land.
    drive_a(1'b1, 4'd3, 16'hDEAD, 2'b11);
    repeat (16) cycle();
    read_all();

    // Byte lanes.
    drive_a(1'b1, 4'd5, 16'hABCD, 2'b11); cycle();
    drive_a(1'b1, 4'd5, 16'h1234, 2'b01); cycle();
    drive_a(1'b0, 4'd5, 16'h0, 2'b00);    cycle();

    // Read-during-write on address 2.
    drive_a(1'b1, 4'd2, 16'h5555, 2'b11); cycle();
    drive_a(1'b1, 4'd2, 16'h00FF, 2'b11);
    drive_b(1'b0, 4'd2, 16'h0, 2'b00);    cycle();
    drive_a(1'b0, 4'd2, 16'h0, 2'b00);    cycle();

    // Write-write collisions on address 7.
    drive_a(1'b1, 4'd7, 16'h1111, 2'b11);
    drive_b(1'b1, 4'd7, 16'h2222, 2'b11); cycle();
    drive_a(1'b0, 4'd7, 16'h0, 2'b00);
    drive_b(1'b0, 4'd7, 16'h0, 2'b00);    cycle();
    drive_a(1'b1, 4'd7, 16'h1111, 2'b10);
    drive_b(1'b1, 4'd7, 16'h2222, 2'b11); cycle();
    drive_a(1'b0, 4'd7, 16'h0, 2'b00);
    drive_b(1'b0, 4'd7, 16'h0, 2'b00);    cycle();

    // Preload 0..3 with 1..4, then back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 4'(i), 16'(i + 1), 2'b11);
      drive_b(1'b0, 4'd9, 16'h0, 2'b00);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 4'(i), 16'h0, 2'b00);
      drive_b(1'b0, 4'(3 - i), 16'h0, 2'b00);
      cycle();
    end

    // Independent writes to different addresses, then crossed reads.
    drive_a(1'b1, 4'd9, 16'h9999, 2'b11);
    drive_b(1'b1, 4'd10, 16'hAAAA, 2'b11); cycle();
    drive_a(1'b0, 4'd10, 16'h0, 2'b00);
    drive_b(1'b0, 4'd9, 16'h0, 2'b00);     cycle();

    // Zero-mask write leaves memory unchanged but still returns data.
    drive_a(1'b1, 4'd9, 16'hFFFF, 2'b00);
    drive_b(1'b0, 4'd9, 16'h0, 2'b00);     cycle();
    drive_a(1'b0, 4'd9, 16'h0, 2'b00);     cycle();

    // Mid-clear reset at clear count 9 restarts the clear.
    drive_a(1'b0, 4'd0, 16'h0, 2'b00);
    drive_b(1'b0, 4'd0, 16'h0, 2'b00);
    do_reset();
    repeat (9) cycle();
    do_reset();
    drive_a(1'b1, 4'd3, 16'hBEEF, 2'b11);
    repeat (16) cycle();
    read_all();

    for (int k = 0; k < 2*NDUT; k++) begin
      check($sformatf("d%0d_pending_%0d", k / 2, k % 2), 16'(sb[k].size()),
            16'(lat_of(k / 2) - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
